// File: rtl/pqc_pkg.sv
// Shared constants for the PQC custom-instruction datapath: ring size, NTT layer count,
// custom-0 decode fields and the NTT address-generator state encoding.
package pqc_pkg;

  localparam int N      = 256;
  localparam int LAYERS = 7;
  localparam int HALF_N = N / 2;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_PQC      = 3'b011;
  localparam logic [6:0] F7_NTT      = 7'b0000011;
  localparam logic [6:0] F7_INTT     = 7'b0000100;
  localparam logic [6:0] F7_PWAM     = 7'b0000101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

  // log2 of the butterfly span: forward shrinks 128..2, inverse grows 2..128.
  function automatic logic [2:0] ntt_len_log2(input logic [2:0] layer, input logic inverse);
    return inverse ? (layer + 3'd1) : (3'd7 - layer);
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-latency shift register carrying a valid flag and an address pair from
// butterfly read issue to writeback; frozen whenever en is low.
module ntt_delay_line #(
  parameter int LAT = 3,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         pending
);

  logic         v_sr [LAT];
  logic [W-1:0] a_sr [LAT];
  logic [W-1:0] b_sr [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        v_sr[i] <= 1'b0;
        a_sr[i] <= '0;
        b_sr[i] <= '0;
      end
    end else if (en) begin
      v_sr[0] <= in_valid;
      a_sr[0] <= in_a;
      b_sr[0] <= in_b;
      for (int i = 1; i < LAT; i++) begin
        v_sr[i] <= v_sr[i-1];
        a_sr[i] <= a_sr[i-1];
        b_sr[i] <= b_sr[i-1];
      end
    end
  end

  assign out_valid = v_sr[LAT-1];
  assign out_a     = a_sr[LAT-1];
  assign out_b     = b_sr[LAT-1];

  // Anything still in flight behind the tail stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pending = pending | v_sr[i];
    end
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// Address sequencer for the 256-point NTT/INTT: issues butterfly read pairs and
// twiddle indices layer by layer, and delays them onto the writeback port.
module ntt_addr_gen
  import pqc_pkg::*;
#(
  parameter int BF_LAT = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inverse,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  output logic              busy,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [6:0]        zeta_idx,
  output logic              ntt_valid,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam logic [2:0] LAST_LAYER = 3'(LAYERS - 1);
  localparam logic [6:0] LAST_BFLY  = 7'(HALF_N - 1);

  logic [1:0]        state;
  logic [2:0]        layer;
  logic [6:0]        bfly;
  logic              inv_q;
  logic [ADDR_W-1:0] base_q;

  logic [2:0]        lg;
  logic [7:0]        len;
  logic [7:0]        ia;
  logic [7:0]        ib;
  logic [6:0]        grp;
  logic [6:0]        zeta;
  logic              pending;

  // The whole operation, including the captured mode and base, freezes under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      layer  <= '0;
      bfly   <= '0;
      inv_q  <= 1'b0;
      base_q <= '0;
    end else if (!stall) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ISSUE;
            layer  <= '0;
            bfly   <= '0;
            inv_q  <= inverse;
            base_q <= base_addr;
          end
        end
        S_ISSUE: begin
          bfly <= bfly + 7'd1;
          if (bfly == LAST_BFLY) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The next layer reads results of this one, so wait for its last write.
          if (ntt_valid && !pending) begin
            if (layer == LAST_LAYER) begin
              state <= S_DONE;
            end else begin
              layer <= layer + 3'd1;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // len is a power of two, so 2*len*g + o reduces to b + (b with the low lg bits cleared).
  always_comb begin
    lg   = ntt_len_log2(layer, inv_q);
    len  = 8'd1 << lg;
    ia   = {1'b0, bfly} + ({1'b0, bfly} & ~(len - 8'd1));
    ib   = ia + len;
    grp  = bfly >> lg;
    if (inv_q) begin
      zeta = 7'((8'd128 >> layer) - 8'd1 - {1'b0, grp});
    end else begin
      zeta = (7'd1 << layer) + grp;
    end
  end

  assign busy     = (state != S_IDLE);
  assign rd_valid = (state == S_ISSUE);
  assign done     = (state == S_DONE) && !stall;

  assign rd_addr_a = rd_valid ? (base_q + ADDR_W'({ia, 2'b00})) : '0;
  assign rd_addr_b = rd_valid ? (base_q + ADDR_W'({ib, 2'b00})) : '0;
  assign zeta_idx  = rd_valid ? zeta : 7'd0;

  ntt_delay_line #(
    .LAT (BF_LAT),
    .W   (ADDR_W)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!stall),
    .in_valid  (rd_valid),
    .in_a      (rd_addr_a),
    .in_b      (rd_addr_b),
    .out_valid (ntt_valid),
    .out_a     (wr_addr_a),
    .out_b     (wr_addr_b),
    .pending   (pending)
  );

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen: expected read/write/done events are queued per run
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_ntt_addr_gen;

  localparam int BF_LAT = 3;
  localparam int ADDR_W = 32;
  localparam int PERIOD = 128 + BF_LAT;
  localparam int FAR    = 1000000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        inverse;
  logic [31:0] base_addr;
  logic        stall;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_addr_a;
  logic [31:0] rd_addr_b;
  logic [6:0]  zeta_idx;
  logic        ntt_valid;
  logic [31:0] wr_addr_a;
  logic [31:0] wr_addr_b;
  logic        done;

  ntt_addr_gen #(.BF_LAT(BF_LAT), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inverse   (inverse),
    .base_addr (base_addr),
    .stall     (stall),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .zeta_idx  (zeta_idx),
    .ntt_valid (ntt_valid),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0    = FAR;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  z;
  } ev_t;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  z;
  } spot_t;

  ev_t   rd_q[$];
  ev_t   wr_q[$];
  int    done_q[$];
  spot_t spot_q[$];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (rel cycle %0d)", name, got, exp, cyc - t0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_ntt_valid"}, 32'(ntt_valid), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_rd_addr_a"}, rd_addr_a, 32'd0);
    checkOutput({tag, "_rd_addr_b"}, rd_addr_b, 32'd0);
    checkOutput({tag, "_wr_addr_a"}, wr_addr_a, 32'd0);
    checkOutput({tag, "_wr_addr_b"}, wr_addr_b, 32'd0);
    checkOutput({tag, "_zeta"}, 32'(zeta_idx), 32'd0);
  endtask

  // Reference butterfly indexing written with plain division and modulo.
  task automatic model(input bit inv, input int l, input int b, input logic [31:0] base,
                       output logic [31:0] a, output logic [31:0] bb, output logic [6:0] z);
    int len;
    int g;
    int o;
    int ia;
    int ib;
    len = inv ? (2 << l) : (128 >> l);
    g   = b / len;
    o   = b % len;
    ia  = 2 * len * g + o;
    ib  = ia + len;
    a   = base + 32'(4 * ia);
    bb  = base + 32'(4 * ib);
    z   = inv ? 7'((128 >> l) - 1 - g) : 7'((1 << l) + g);
  endtask

  task automatic addSpot(input int c, input bit wr, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] z);
    spot_t s;
    s.cyc = c; s.wr = wr; s.a = a; s.b = b; s.z = z;
    spot_q.push_back(s);
  endtask

  // Monitor: a transfer is presented when a valid is high and the pipe is not stalled.
  always @(negedge clk) begin
    ev_t   e;
    spot_t s;
    int    dc;
    if (rd_valid && !stall) begin
      if (rd_q.size() == 0) begin
        checkOutput("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        checkOutput("rd_cycle", 32'(cyc - t0), 32'(e.cyc));
        checkOutput("rd_addr_a", rd_addr_a, e.a);
        checkOutput("rd_addr_b", rd_addr_b, e.b);
        checkOutput("zeta_idx", 32'(zeta_idx), 32'(e.z));
      end
    end
    if (ntt_valid && !stall) begin
      if (wr_q.size() == 0) begin
        checkOutput("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = wr_q.pop_front();
        checkOutput("wr_cycle", 32'(cyc - t0), 32'(e.cyc));
        checkOutput("wr_addr_a", wr_addr_a, e.a);
        checkOutput("wr_addr_b", wr_addr_b, e.b);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checkOutput("done_unexpected", 32'd1, 32'd0);
      end else begin
        dc = done_q.pop_front();
        checkOutput("done_cycle", 32'(cyc - t0), 32'(dc));
      end
    end
    if (spot_q.size() > 0 && (cyc - t0) == spot_q[0].cyc) begin
      s = spot_q.pop_front();
      if (s.wr) begin
        checkOutput("spot_ntt_valid", 32'(ntt_valid), 32'd1);
        checkOutput("spot_wr_addr_a", wr_addr_a, s.a);
        checkOutput("spot_wr_addr_b", wr_addr_b, s.b);
      end else begin
        checkOutput("spot_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("spot_rd_addr_a", rd_addr_a, s.a);
        checkOutput("spot_rd_addr_b", rd_addr_b, s.b);
        checkOutput("spot_zeta", 32'(zeta_idx), 32'(s.z));
      end
    end
  end

  task automatic gotoRel(input int r);
    while ((cyc - t0) < r) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full operation; negative stall_at/abort_at/dup_at disable that event.
  task automatic applyStimulus(input bit inv, input logic [31:0] base, input int stall_at,
                               input int abort_at, input int dup_at);
    logic [31:0] fa;
    logic [31:0] fw;
    logic        fv;
    logic [6:0]  fz;
    ev_t         e;
    int          rc;
    int          wc;
    for (int l = 0; l < 7; l++) begin
      for (int b = 0; b < 128; b++) begin
        model(inv, l, b, base, e.a, e.b, e.z);
        rc = 1 + PERIOD * l + b;
        wc = rc + BF_LAT;
        if (abort_at < 0 || rc <= abort_at) begin
          e.cyc = (stall_at >= 0 && rc >= stall_at) ? rc + 5 : rc;
          rd_q.push_back(e);
        end
        if (abort_at < 0 || wc <= abort_at) begin
          e.cyc = (stall_at >= 0 && wc >= stall_at) ? wc + 5 : wc;
          wr_q.push_back(e);
        end
      end
    end
    if (abort_at < 0) begin
      done_q.push_back(1 + 7 * PERIOD + ((stall_at >= 0) ? 5 : 0));
    end

    @(posedge clk);
    #1;
    t0        = cyc;
    inverse   = inv;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    if (dup_at >= 0) begin
      gotoRel(dup_at);
      start     = 1'b1;
      inverse   = ~inv;
      base_addr = 32'hDEAD_BEE0;
      @(posedge clk);
      #1;
      start = 1'b0;
    end

    if (stall_at >= 0) begin
      gotoRel(stall_at);
      stall = 1'b1;
      @(negedge clk);
      fa = rd_addr_a; fw = wr_addr_a; fv = ntt_valid; fz = zeta_idx;
      repeat (4) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("stall_rd_addr_a", rd_addr_a, fa);
        checkOutput("stall_zeta", 32'(zeta_idx), 32'(fz));
        checkOutput("stall_ntt_valid", 32'(ntt_valid), 32'(fv));
        checkOutput("stall_wr_addr_a", wr_addr_a, fw);
        checkOutput("stall_done", 32'(done), 32'd0);
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
    end

    if (abort_at >= 0) begin
      gotoRel(abort_at);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkAllZero("abort");
      repeat (30) @(posedge clk);
      #1;
      checkAllZero("abort_idle");
    end else begin
      while (done_q.size() > 0 && (cyc - t0) < 1200) begin
        @(posedge clk);
        #1;
      end
      if (done_q.size() > 0) begin
        checkOutput("done_timeout", 32'(done_q.size()), 32'd0);
        done_q.delete();
      end
      repeat (5) @(posedge clk);
      #1;
      checkOutput("idle_after_done_busy", 32'(busy), 32'd0);
    end

    checkOutput("rd_left", 32'(rd_q.size()), 32'd0);
    checkOutput("wr_left", 32'(wr_q.size()), 32'd0);
    checkOutput("spot_left", 32'(spot_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
    spot_q.delete();
    t0 = FAR;
  endtask

  task automatic forwardSpots();
    addSpot(1,   1'b0, 32'h1000, 32'h1200, 7'd1);
    addSpot(4,   1'b1, 32'h1000, 32'h1200, 7'd0);
    addSpot(132, 1'b0, 32'h1000, 32'h1100, 7'd2);
    addSpot(787, 1'b0, 32'h1000, 32'h1008, 7'd64);
    addSpot(914, 1'b0, 32'h13F4, 32'h13FC, 7'd127);
    addSpot(917, 1'b1, 32'h13F4, 32'h13FC, 7'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    inverse   = 1'b0;
    stall     = 1'b0;
    base_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("post_reset");

    $display("[TB] forward run, base 0x1000, repeated start at cycle 50");
    forwardSpots();
    applyStimulus(1'b0, 32'h1000, -1, -1, 50);

    $display("[TB] inverse run, base 0x1000");
    addSpot(1,   1'b0, 32'h1000, 32'h1008, 7'd127);
    addSpot(128, 1'b0, 32'h13F4, 32'h13FC, 7'd64);
    addSpot(787, 1'b0, 32'h1000, 32'h1200, 7'd1);
    applyStimulus(1'b1, 32'h1000, -1, -1, -1);

    $display("[TB] forward run with 5-cycle stall at cycle 300");
    addSpot(1,   1'b0, 32'h1000, 32'h1200, 7'd1);
    addSpot(305, 1'b0, 32'h1114, 32'h1194, 7'd5);
    addSpot(792, 1'b0, 32'h1000, 32'h1008, 7'd64);
    applyStimulus(1'b0, 32'h1000, 300, -1, -1);

    $display("[TB] wrapping base, repeated start at 50, reset at 300");
    addSpot(1,   1'b0, 32'hFFFF_FE00, 32'h0000_0000, 7'd1);
    addSpot(128, 1'b0, 32'hFFFF_FFFC, 32'h0000_01FC, 7'd1);
    applyStimulus(1'b0, 32'hFFFF_FE00, -1, 300, 50);

    $display("[TB] fresh forward run after abort");
    forwardSpots();
    applyStimulus(1'b0, 32'h1000, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
